// File: rtl/lut_sched_pkg.sv
// Shared constants and FSM state encoding for the LUT layer scheduler.
// Each neuron is a 6-input, 1-bit LUT described by a 64-entry truth table.
package lut_sched_pkg;

  localparam int FANIN    = 6;
  localparam int TT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lut_neuron_bank.sv
// Truth-table and connection storage for every neuron, with guarded config writes.
// Reads are combinational on rd_idx so the scheduler can evaluate one neuron per cycle.
module lut_neuron_bank
  import lut_sched_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = 6,
  parameter int NSEL_W      = 5,
  parameter int CNT_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_allow,
  input  logic                     cfg_tt_we,
  input  logic                     cfg_conn_we,
  input  logic [NSEL_W-1:0]        cfg_neuron,
  input  logic [TT_WIDTH-1:0]      cfg_tt_data,
  input  logic [FANIN*IDX_W-1:0]   cfg_conn_data,
  input  logic [CNT_W-1:0]         rd_idx,
  output logic [TT_WIDTH-1:0]      rd_tt,
  output logic [FANIN*IDX_W-1:0]   rd_conn,
  output logic                     cfg_err
);

  localparam logic [NSEL_W-1:0] NUM_N = NSEL_W'(NUM_NEURONS);

  logic [TT_WIDTH-1:0]    tt_q   [NUM_NEURONS];
  logic [FANIN*IDX_W-1:0] conn_q [NUM_NEURONS];
  logic                   cfg_err_q;
  logic                   cfg_err_d;
  logic                   any_we;
  logic                   wr_ok;

  always_comb begin
    any_we    = cfg_tt_we | cfg_conn_we;
    wr_ok     = any_we & cfg_allow & (cfg_neuron < NUM_N);
    // Both strobes share one neuron select, so a combined write is all-or-nothing.
    cfg_err_d = any_we & ~wr_ok;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_store
      logic sel;
      assign sel = wr_ok & (cfg_neuron == NSEL_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tt_q[gi]   <= '0;
          conn_q[gi] <= '0;
        end else begin
          if (sel && cfg_tt_we)   tt_q[gi]   <= cfg_tt_data;
          if (sel && cfg_conn_we) conn_q[gi] <= cfg_conn_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_err_d;
  end

  assign rd_tt   = tt_q[rd_idx];
  assign rd_conn = conn_q[rd_idx];
  assign cfg_err = cfg_err_q;

endmodule

// File: rtl/lut_layer_scheduler.sv
// Evaluates one layer of 6-input LUT neurons, one neuron per cycle, over a captured
// input vector, then presents the packed result under a valid/ready handshake.
module lut_layer_scheduler
  import lut_sched_pkg::*;
#(
  parameter int IN_WIDTH    = 32,
  parameter int NUM_NEURONS = 16,
  // One spare bit on each index so out-of-range values are representable and handled.
  localparam int IDX_W  = $clog2(IN_WIDTH) + 1,
  localparam int NSEL_W = $clog2(NUM_NEURONS) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_data,
  input  logic                   cfg_tt_we,
  input  logic                   cfg_conn_we,
  input  logic [NSEL_W-1:0]      cfg_neuron,
  input  logic [TT_WIDTH-1:0]    cfg_tt_data,
  input  logic [FANIN*IDX_W-1:0] cfg_conn_data,
  output logic                   cfg_err,
  output logic                   busy
);

  localparam int                CNT_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int                IBIT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W-1:0]  IN_LIM = IDX_W'(IN_WIDTH);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]    in_cap_q, in_cap_d;
  logic [NUM_NEURONS-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;

  logic [TT_WIDTH-1:0]    rd_tt;
  logic [FANIN*IDX_W-1:0] rd_conn;
  logic [FANIN-1:0]       lut_addr;
  logic                   cfg_allow;

  assign cfg_allow = (state_q == IDLE) & ~in_valid;

  lut_neuron_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .NSEL_W      (NSEL_W),
    .CNT_W       (CNT_W)
  ) u_bank (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_allow     (cfg_allow),
    .cfg_tt_we     (cfg_tt_we),
    .cfg_conn_we   (cfg_conn_we),
    .cfg_neuron    (cfg_neuron),
    .cfg_tt_data   (cfg_tt_data),
    .cfg_conn_data (cfg_conn_data),
    .rd_idx        (cnt_q),
    .rd_tt         (rd_tt),
    .rd_conn       (rd_conn),
    .cfg_err       (cfg_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < FANIN; gi++) begin : g_addr
      logic [IDX_W-1:0] idx;
      assign idx = rd_conn[gi*IDX_W +: IDX_W];
      // Indices past the input vector read as a constant 0.
      assign lut_addr[gi] = (idx < IN_LIM) ? in_cap_q[idx[IBIT_W-1:0]] : 1'b0;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_cap_d   = in_cap_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_cap_d = in_data;
          cnt_d    = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        out_data_d[cnt_q] = rd_tt[lut_addr];
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_cap_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_cap_q    <= in_cap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
